// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared FSM states, key map and column helpers for the 4x4 keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    REL_DEB
  } keypad_state_e;

  // Indexed by {row, col}; entry 0 is row 0 / col 0.
  localparam logic [15:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [1:0] col_rotate(input logic [1:0] col);
    return col + 2'd1;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// rtl/keypad_tick_gen.sv - free-running divider emitting a one-clock scan tick every SCAN_DIV+1 clocks
module keypad_tick_gen #(
  parameter int SCAN_DIV = 250000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(SCAN_DIV));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan_4x4.sv
// rtl/keypad_scan_4x4.sv - 4x4 matrix keypad scanner with debounce and valid/ack key output.
// Defining KEYPAD_SHIFT_EN adds the digits port: a nibble shift register of accepted keys.
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_DIV       = 250000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        key_held,
  output logic        key_overrun
`ifdef KEYPAD_SHIFT_EN
  ,
  output logic [31:0] digits
`endif
);

  localparam int DW = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_SCANS);

  logic          scan_tick;
  logic [3:0]    row_m_q, row_s_q;
  keypad_state_e state_q, state_d;
  logic [1:0]    col_q, col_d, row_idx_q, row_idx_d;
  logic [DW-1:0] deb_q, deb_d, deb_inc;
  logic          accept, ack_ok, row_active;
  logic [3:0]    accept_code;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d, ovr_q, ovr_d;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (scan_tick)
  );

  // Column changes must settle through the synchronizer before the next tick samples rows.
  p_params: assert property (@(posedge clk)
    (CLK_HZ > 0) && (SCAN_DIV >= 2) && (DEBOUNCE_SCANS >= 1));

  assign deb_inc    = deb_q + DW'(1);
  assign row_active = !row_s_q[row_idx_q];

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    deb_d     = deb_q;
    accept    = 1'b0;
    if (scan_tick) begin
      case (state_q)
        SCAN: begin
          if (row_s_q == 4'hF) begin
            col_d = col_rotate(col_q);
          end else begin
            row_idx_d = low_row(row_s_q);
            deb_d     = DW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_d = PRESSED;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (row_active) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_TARGET) begin
              accept  = 1'b1;
              state_d = PRESSED;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_rotate(col_q);
          end
        end
        PRESSED: begin
          if (!row_active) begin
            deb_d = DW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_d = SCAN;
              col_d   = col_rotate(col_q);
            end else begin
              state_d = REL_DEB;
            end
          end
        end
        REL_DEB: begin
          if (!row_active) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_TARGET) begin
              state_d = SCAN;
              col_d   = col_rotate(col_q);
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign accept_code = KEY_MAP[{row_idx_d, col_q}];
  assign ack_ok      = key_ack && valid_q;

  // A same-cycle ack frees the slot, so the new press is loaded instead of counted as overrun.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (ack_ok) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (accept) begin
      if (!valid_q || ack_ok) begin
        code_d  = accept_code;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m_q   <= 4'hF;
      row_s_q   <= 4'hF;
      state_q   <= SCAN;
      col_q     <= 2'd0;
      row_idx_q <= 2'd0;
      deb_q     <= '0;
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      row_m_q   <= row_in;
      row_s_q   <= row_m_q;
      state_q   <= state_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      deb_q     <= deb_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef KEYPAD_SHIFT_EN
  logic [31:0] digits_q, digits_d;

  always_comb begin
    digits_d = digits_q;
    if (accept) digits_d = {digits_q[27:0], accept_code};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digits_q <= 32'h0;
    else     digits_q <= digits_d;
  end

  assign digits = digits_q;
`endif

  assign col_out     = col_drive(col_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_overrun = ovr_q;
  assign key_held    = (state_q == PRESSED) || (state_q == REL_DEB);

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb/tb_keypad_scan_4x4.sv - self-checking bench for keypad_scan_4x4 with a pull-down keypad model
module tb_keypad_scan_4x4;

  localparam int SD = 4;
  localparam int DS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, key_ack, key_held, key_overrun;
`ifdef KEYPAD_SHIFT_EN
  logic [31:0] digits;
`endif
  logic [15:0] keys;
  int          total = 0;
  int          bad = 0;

  keypad_scan_4x4 #(.CLK_HZ(100_000_000), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .key_overrun (key_overrun)
`ifdef KEYPAD_SHIFT_EN
    ,
    .digits      (digits)
`endif
  );

  always #5 clk = ~clk;

  // A pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
  } vec_t;

  function automatic logic [3:0] exp_key(input int r, input int c);
    string s;
    byte   ch;
    case (r)
      0:       s = "123A";
      1:       s = "456B";
      2:       s = "789C";
      default: s = "E0FD";
    endcase
    ch = s[c];
    if (ch >= 8'h41) return 4'(ch - 8'h37);
    return 4'(ch - 8'h30);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input bit use_held, input logic lvl, input int budget, output int n);
    n = 0;
    while (((use_held ? key_held : key_valid) !== lvl) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((use_held ? key_held : key_valid) !== lvl) begin
      total++;
      bad++;
      $display("FAIL timeout waiting for %s=%0b after %0d clk", use_held ? "key_held" : "key_valid", lvl, n);
    end
  endtask

  task automatic do_ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  // Returns at the first negedge after the scan moves onto column 0.
  task automatic sync_col0();
    logic [3:0] prev;
    prev = col_out;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (prev != 4'b1110 && col_out == 4'b1110) return;
      prev = col_out;
    end
    total++;
    bad++;
    $display("FAIL sync_col0: column 0 never reached");
  endtask

  task automatic press_release(input int r, input int c, input logic [3:0] code, input string name);
    int n;
    keys[r*4+c] = 1'b1;
    wait_for(1'b0, 1'b1, 200, n);
    check(name, key_code, code);
    do_ack();
    check({name, "_ack"}, key_valid, 1'b0);
    keys = '0;
    wait_for(1'b1, 1'b0, 200, n);
  endtask

  vec_t       tbl[8];
  int         n;
  logic [3:0] exp_col;
  logic       mv, mo;
  logic [3:0] mc;
  int         rr, cc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 3, 4'hA};
    tbl[1] = '{1, 1, 4'h5};
    tbl[2] = '{2, 0, 4'h7};
    tbl[3] = '{2, 2, 4'h9};
    tbl[4] = '{3, 0, 4'hE};
    tbl[5] = '{3, 2, 4'hF};
    tbl[6] = '{3, 3, 4'hD};
    tbl[7] = '{1, 3, 4'hB};

    keys    = '0;
    key_ack = 1'b0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", col_out, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    check("rst_ovr", key_overrun, 1'b0);
`ifdef KEYPAD_SHIFT_EN
    check("rst_digits", digits, 32'h0);
`endif
    rst = 1'b0;

    // Idle scan: one column step every SD+1 clocks.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4 || i % 5 == 0) begin
        exp_col = ~(4'b0001 << ((i / 5) % 4));
        check($sformatf("idle_col_%0d", i), col_out, exp_col);
      end
    end
    check("idle_valid", key_valid, 1'b0);

    // Long hold of r1c2 yields a single event.
    keys[1*4+2] = 1'b1;
    wait_for(1'b0, 1'b1, 200, n);
    check("hold_code", key_code, 4'h6);
    repeat (30) @(negedge clk);
    check("hold_valid", key_valid, 1'b1);
    check("hold_once", key_overrun, 1'b0);
    check("hold_held", key_held, 1'b1);
    do_ack();
    check("hold_ack", key_valid, 1'b0);
    keys = '0;
    wait_for(1'b1, 1'b0, 200, n);

    for (int i = 0; i < 8; i++)
      press_release(tbl[i].row, tbl[i].col, tbl[i].code, $sformatf("tbl_%0d", i));

    // Bounce: low for two ticks only.
    sync_col0();
    keys[0] = 1'b1;
    repeat (7) @(negedge clk);
    check("bounce_frozen", col_out, 4'b1110);
    repeat (3) @(negedge clk);
    keys = '0;
    repeat (5) @(negedge clk);
    check("bounce_col1", col_out, 4'b1101);
    check("bounce_held", key_held, 1'b0);
    repeat (40) @(negedge clk);
    check("bounce_valid", key_valid, 1'b0);

    // Overrun: second press with no ack.
    keys[3*4+1] = 1'b1;
    wait_for(1'b0, 1'b1, 200, n);
    check("ovr_first", key_code, 4'h0);
    keys = '0;
    wait_for(1'b1, 1'b0, 200, n);
    keys[2*4+3] = 1'b1;
    wait_for(1'b1, 1'b1, 200, n);
    @(negedge clk);
    check("ovr_code", key_code, 4'h0);
    check("ovr_valid", key_valid, 1'b1);
    check("ovr_flag", key_overrun, 1'b1);
    do_ack();
    check("ovr_ack_valid", key_valid, 1'b0);
    check("ovr_ack_flag", key_overrun, 1'b0);
    keys = '0;
    wait_for(1'b1, 1'b0, 200, n);

    // Ack lands on the accept edge: new code loads, no overrun.
    keys[3*4+1] = 1'b1;
    wait_for(1'b0, 1'b1, 200, n);
    keys = '0;
    wait_for(1'b1, 1'b0, 200, n);
    sync_col0();
    keys[0] = 1'b1;
    repeat (14) @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("same_valid", key_valid, 1'b1);
    check("same_code", key_code, 4'h1);
    check("same_ovr", key_overrun, 1'b0);
    do_ack();
    keys = '0;
    wait_for(1'b1, 1'b0, 200, n);

    // Two keys in one column: lowest row wins; release debounce length.
    keys[0*4+1] = 1'b1;
    keys[2*4+1] = 1'b1;
    wait_for(1'b0, 1'b1, 200, n);
    check("multi_code", key_code, 4'h2);
    do_ack();
    repeat (30) @(negedge clk);
    check("multi_once", key_valid, 1'b0);
    keys = '0;
    wait_for(1'b1, 1'b0, 200, n);
    total++;
    if (n < 13 || n > 17) begin
      bad++;
      $display("FAIL release_time: held dropped after %0d clk, expected 13..17", n);
    end

    // Reset while PRESSED, key kept down.
    keys[1*4+0] = 1'b1;
    wait_for(1'b1, 1'b1, 200, n);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_col", col_out, 4'b1110);
    check("midrst_valid", key_valid, 1'b0);
    check("midrst_code", key_code, 4'h0);
    check("midrst_held", key_held, 1'b0);
    check("midrst_ovr", key_overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_for(1'b0, 1'b1, 200, n);
    check("midrst_new", key_code, 4'h4);
    repeat (30) @(negedge clk);
    check("midrst_once", key_overrun, 1'b0);
    do_ack();
    keys = '0;
    wait_for(1'b1, 1'b0, 200, n);

    // Random presses against an event-level handshake model.
    mv = 1'b0;
    mo = 1'b0;
    mc = 4'h0;
    for (int it = 0; it < 12; it++) begin
      rr = $urandom_range(0, 3);
      cc = $urandom_range(0, 3);
      keys[rr*4+cc] = 1'b1;
      wait_for(1'b1, 1'b1, 200, n);
      @(negedge clk);
      if (mv) mo = 1'b1;
      else begin
        mc = exp_key(rr, cc);
        mv = 1'b1;
      end
      check($sformatf("rnd_valid_%0d", it), key_valid, mv);
      check($sformatf("rnd_code_%0d", it), key_code, mc);
      check($sformatf("rnd_ovr_%0d", it), key_overrun, mo);
      keys = '0;
      wait_for(1'b1, 1'b0, 200, n);
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        mv = 1'b0;
        mo = 1'b0;
        check($sformatf("rnd_ackv_%0d", it), key_valid, mv);
        check($sformatf("rnd_acko_%0d", it), key_overrun, mo);
      end
    end

`ifdef KEYPAD_SHIFT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    press_release(0, 0, 4'h1, "shift_1");
    press_release(0, 1, 4'h2, "shift_2");
    press_release(0, 2, 4'h3, "shift_3");
    check("shift_digits", digits, 32'h0000_0123);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
